raster_scan_counter: RTL and testbench
======================================

Name: raster_scan_counter

Overview:
- Parametrised pixel-address generator for the Mandelbrot iteration datapath.
- Walks the image in raster order, top-left to bottom-right, advancing STEP pixels per accepted beat.
- Presents x, y and the linear frame-buffer address to the downstream iteration engine over a valid/ready handshake.
- Supports single-frame and continuous (free-running) modes, with line/frame markers and a frame counter.

Parameters:
- IMG_W, 320, image width in pixels; must be a multiple of STEP.
- IMG_H, 240, image height in lines; must be >= 1.
- STEP, 4, pixels advanced per accepted beat (pixels processed in parallel downstream).
- X_W, 9, width of x output; must satisfy 2^X_W >= IMG_W.
- Y_W, 8, width of y output; must satisfy 2^Y_W >= IMG_H.
- ADDR_W, 17, width of linear address; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- CONTINUOUS, 0, selects frame-end behaviour: 0 = stop after one frame; 1 = wrap and rescan forever.

Ports:
- clk, in, 1, clock; all logic is on the rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, begins a scan; sampled only in IDLE.
- ready, in, 1, downstream accepts the current beat.
- valid, out, 1, x/y/addr hold a valid beat.
- x, out, X_W, column of the first pixel in the beat.
- y, out, Y_W, row of the beat.
- addr, out, ADDR_W, linear address, equal to y*IMG_W + x.
- line_last, out, 1, high while the current beat is the last beat of its line.
- frame_last, out, 1, high while the current beat is the last beat of the frame.
- busy, out, 1, high while in SCAN.
- done, out, 1, one-cycle pulse after a single-frame scan completes.
- frame_count, out, 8, number of completed frames; wraps 255 -> 0.

Behaviour:
- Reset: state IDLE. valid, x, y, addr, busy, done and frame_count are all 0. Reset wins over every other input, including in the middle of a scan.
- Handshake: a beat is accepted when valid && ready are both high on a clock edge. While valid=1 and ready=0, x, y and addr hold stable. valid never drops without acceptance, except on rst.
- FSM states: IDLE, SCAN, DONE.
- IDLE: valid=0. start=1 -> SCAN with x=y=addr=0; valid=1 from the next cycle.
- SCAN: valid=1 and busy=1. On each accepted beat:
  - Not last of line: x += STEP, addr += STEP.
  - Last of line, i.e. x == IMG_W-STEP: x=0, y += 1, addr += STEP.
  - Last of frame (line_last && y == IMG_H-1): frame_count += 1; x=y=addr=0. If CONTINUOUS=0 -> DONE and valid=0 next cycle. If CONTINUOUS=1 -> stay in SCAN with valid=1, with no bubble cycle.
- DONE: lasts exactly 1 cycle; done=1 and valid=0, then -> IDLE.
- start is ignored outside IDLE. start held high in IDLE after DONE begins a new scan on the next cycle.
- addr is maintained incrementally; no multiplier. It must equal y*IMG_W + x for every beat.
- line_last and frame_last are combinational from the current x/y and are asserted only while valid=1.
- Boundary cases:
  - IMG_H=1: every beat's line_last doubles as frame_last.
  - STEP == IMG_W: every beat is line_last.
  - frame_count wraps silently.
- Latency: start -> first valid = 1 cycle. Final acceptance -> done = 1 cycle.

Test Plan:
- Params IMG_W=8, IMG_H=2, STEP=4, CONTINUOUS=0, ready held 1. Pulse start -> 4 beats: (x,y,addr) = (0,0,0), (4,0,4), (0,1,8), (4,1,12). line_last on beats 2 and 4; frame_last on beat 4. Next cycle: done=1 and valid=0. frame_count=1, then IDLE.
- Same params, ready toggling 1,0,0,1,... -> outputs hold stable through the ready=0 cycles. The beat sequence is identical, no beat is skipped or duplicated, and the addr == y*8 + x check passes on every beat.
- CONTINUOUS=1, ready=1, run 3 frames -> beat 4 (4,1,12) is followed directly by (0,0,0) with valid high throughout. done is never asserted. frame_count reads 3 after the 12th beat.
- Default params (320x240, STEP=4), full run -> exactly 19200 beats. Last beat is x=316, y=239, addr=76796, followed by a done pulse.
- rst asserted in SCAN at beat (4,0,4) -> next cycle: valid=0, IDLE, x=y=addr=0, frame_count=0. A subsequent start restarts at (0,0,0).
- start pulsed during SCAN and during DONE -> ignored: the beat sequence is unaffected and only one done pulse is produced.

Source files
------------

// File: rtl/raster_scan_counter.sv
// raster_scan_counter
//   Pixel-address generator for the Mandelbrot iteration datapath. It walks
//   the image in raster order, top-left to bottom-right, and advances STEP
//   pixels for each beat the downstream engine accepts. Each beat carries the
//   column, the row and the linear frame-buffer address over a valid/ready
//   handshake.
//
//   In single-frame mode (CONTINUOUS=0) the scan stops after one frame and
//   pulses done. In continuous mode the scan wraps back to pixel 0 with no
//   bubble cycle and never pulses done.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset; overrides everything
//   start       in   begins a scan; only looked at while idle
//   ready       in   downstream accepts the current beat
//   valid       out  x/y/addr carry a beat
//   x           out  column of the first pixel in the beat
//   y           out  row of the beat
//   addr        out  linear address, always y*IMG_W + x
//   line_last   out  current beat is the last one of its line
//   frame_last  out  current beat is the last one of the frame
//   busy        out  scan in progress
//   done        out  one-cycle pulse after a single-frame scan
//   frame_count out  completed frames, wraps 255 -> 0

module raster_scan_counter #(
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int STEP       = 4,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int ADDR_W     = 17,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ready,
  output logic              valid,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              line_last,
  output logic              frame_last,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_count
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [X_W-1:0]    X_LAST = X_W'(IMG_W - STEP);
  localparam logic [Y_W-1:0]    Y_LAST = Y_W'(IMG_H - 1);
  localparam logic [X_W-1:0]    X_STEP = X_W'(STEP);
  localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(STEP);

  state_t state;
  state_t next_state;

  logic accept;
  logic line_end;
  logic frame_end;

  // Position decodes. These are raw comparisons on the counters. The
  // outputs below gate them with valid so the markers never show outside a
  // beat.
  assign accept    = valid && ready;
  assign line_end  = (x == X_LAST);
  assign frame_end = line_end && (y == Y_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. DONE always lasts one cycle, so a start seen during
  // DONE is dropped. A start that is still high once the FSM is back in IDLE
  // launches the next frame.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SCAN;
        end
      end
      SCAN: begin
        if (accept && frame_end && !CONTINUOUS) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    valid      = (state == SCAN);
    busy       = (state == SCAN);
    done       = (state == DONE);
    line_last  = (state == SCAN) && line_end;
    frame_last = (state == SCAN) && frame_end;
  end

  // Position counters. addr is stepped alongside x instead of being computed
  // as y*IMG_W + x. The image width is a multiple of STEP, so the address of
  // the next beat is always addr + STEP, even across a line wrap. The
  // counters return to zero at the end of every frame, which means a new
  // scan (or a continuous wrap) always starts from pixel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      frame_count <= '0;
    end else if (state == IDLE && start) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (accept) begin
      if (frame_end) begin
        x           <= '0;
        y           <= '0;
        addr        <= '0;
        frame_count <= frame_count + 8'd1;
      end else if (line_end) begin
        x    <= '0;
        y    <= y + 1'b1;
        addr <= addr + A_STEP;
      end else begin
        x    <= x + X_STEP;
        addr <= addr + A_STEP;
      end
    end
  end

endmodule

// File: tb/tb_raster_scan_counter.sv
// tb_raster_scan_counter
//   Bench for raster_scan_counter. Four instances cover different geometries:
//     sm : 8x2, STEP 4, single frame
//     ct : 8x2, STEP 4, continuous
//     ed : 4x1, STEP 4, continuous (IMG_H=1 and STEP==IMG_W together)
//     fl : default 320x240, STEP 4, single frame
//   The expected beat for the k-th accepted beat of a frame is pixel k*STEP
//   of the image. x and y come from that pixel number by division and
//   modulo. Inputs change on the falling edge and outputs are read there.

module tb_raster_scan_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int sm_frames   = 0;

  // sm instance
  logic       sm_rst, sm_start, sm_ready;
  logic       sm_valid, sm_ll, sm_fl, sm_busy, sm_done;
  logic [2:0] sm_x;
  logic [0:0] sm_y;
  logic [3:0] sm_addr;
  logic [7:0] sm_fc;

  // ct instance
  logic       ct_rst, ct_start, ct_ready;
  logic       ct_valid, ct_ll, ct_fl, ct_busy, ct_done;
  logic [2:0] ct_x;
  logic [0:0] ct_y;
  logic [3:0] ct_addr;
  logic [7:0] ct_fc;

  // ed instance
  logic       ed_rst, ed_start, ed_ready;
  logic       ed_valid, ed_ll, ed_fl, ed_busy, ed_done;
  logic [1:0] ed_x;
  logic [0:0] ed_y;
  logic [1:0] ed_addr;
  logic [7:0] ed_fc;

  // fl instance
  logic        fl_rst, fl_start, fl_ready;
  logic        fl_valid, fl_ll, fl_fl, fl_busy, fl_done;
  logic [8:0]  fl_x;
  logic [7:0]  fl_y;
  logic [16:0] fl_addr;
  logic [7:0]  fl_fc;

  raster_scan_counter #(.IMG_W(8), .IMG_H(2), .STEP(4), .X_W(3), .Y_W(1),
                        .ADDR_W(4), .CONTINUOUS(1'b0)) dut_sm (
    .clk(clk), .rst(sm_rst), .start(sm_start), .ready(sm_ready),
    .valid(sm_valid), .x(sm_x), .y(sm_y), .addr(sm_addr),
    .line_last(sm_ll), .frame_last(sm_fl), .busy(sm_busy),
    .done(sm_done), .frame_count(sm_fc));

  raster_scan_counter #(.IMG_W(8), .IMG_H(2), .STEP(4), .X_W(3), .Y_W(1),
                        .ADDR_W(4), .CONTINUOUS(1'b1)) dut_ct (
    .clk(clk), .rst(ct_rst), .start(ct_start), .ready(ct_ready),
    .valid(ct_valid), .x(ct_x), .y(ct_y), .addr(ct_addr),
    .line_last(ct_ll), .frame_last(ct_fl), .busy(ct_busy),
    .done(ct_done), .frame_count(ct_fc));

  raster_scan_counter #(.IMG_W(4), .IMG_H(1), .STEP(4), .X_W(2), .Y_W(1),
                        .ADDR_W(2), .CONTINUOUS(1'b1)) dut_ed (
    .clk(clk), .rst(ed_rst), .start(ed_start), .ready(ed_ready),
    .valid(ed_valid), .x(ed_x), .y(ed_y), .addr(ed_addr),
    .line_last(ed_ll), .frame_last(ed_fl), .busy(ed_busy),
    .done(ed_done), .frame_count(ed_fc));

  raster_scan_counter dut_fl (
    .clk(clk), .rst(fl_rst), .start(fl_start), .ready(fl_ready),
    .valid(fl_valid), .x(fl_x), .y(fl_y), .addr(fl_addr),
    .line_last(fl_ll), .frame_last(fl_fl), .busy(fl_busy),
    .done(fl_done), .frame_count(fl_fc));

  task automatic test_reset();
    sm_rst = 1'b1; ct_rst = 1'b1; ed_rst = 1'b1; fl_rst = 1'b1;
    sm_start = 1'b1; ct_start = 1'b1; ed_start = 1'b1; fl_start = 1'b1;
    sm_ready = 1'b1; ct_ready = 1'b1; ed_ready = 1'b1; fl_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({sm_valid, sm_busy, sm_done, sm_x, sm_y, sm_addr, sm_fc} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_sm: got v=%b b=%b d=%b x=%0d y=%0d a=%0d fc=%0d want all 0",
               sm_valid, sm_busy, sm_done, sm_x, sm_y, sm_addr, sm_fc);
    end
    vectors++;
    if ({ct_valid, ct_busy, ct_done, ct_x, ct_y, ct_addr, ct_fc} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_ct: got v=%b b=%b d=%b x=%0d y=%0d a=%0d fc=%0d want all 0",
               ct_valid, ct_busy, ct_done, ct_x, ct_y, ct_addr, ct_fc);
    end
    vectors++;
    if ({ed_valid, ed_busy, ed_done, ed_x, ed_y, ed_addr, ed_fc} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_ed: got v=%b b=%b d=%b fc=%0d want all 0",
               ed_valid, ed_busy, ed_done, ed_fc);
    end
    vectors++;
    if ({fl_valid, fl_busy, fl_done, fl_x, fl_y, fl_addr, fl_fc} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_fl: got v=%b b=%b d=%b x=%0d y=%0d a=%0d fc=%0d want all 0",
               fl_valid, fl_busy, fl_done, fl_x, fl_y, fl_addr, fl_fc);
    end
    sm_rst = 1'b0; ct_rst = 1'b0; ed_rst = 1'b0; fl_rst = 1'b0;
    sm_start = 1'b0; ct_start = 1'b0; ed_start = 1'b0; fl_start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sm_valid, ct_valid, ed_valid, fl_valid} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_release_idle: got valids=%b want 0000",
               {sm_valid, ct_valid, ed_valid, fl_valid});
    end
  endtask

  task automatic test_single_frame();
    int ex[4]  = '{0, 4, 0, 4};
    int ey[4]  = '{0, 0, 1, 1};
    int ea[4]  = '{0, 4, 8, 12};
    int ell[4] = '{0, 1, 0, 1};
    int efl[4] = '{0, 0, 0, 1};
    sm_ready = 1'b1;
    sm_start = 1'b1;
    @(negedge clk);
    sm_start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      vectors++;
      if (sm_valid !== 1'b1 || sm_busy !== 1'b1 || sm_x !== ex[b] || sm_y !== ey[b] ||
          sm_addr !== ea[b] || sm_ll !== ell[b] || sm_fl !== efl[b]) begin
        miscompares++;
        $display("[TB] FAIL single_beat%0d: got v=%b b=%b x=%0d y=%0d a=%0d ll=%b fl=%b want v=1 b=1 x=%0d y=%0d a=%0d ll=%0d fl=%0d",
                 b, sm_valid, sm_busy, sm_x, sm_y, sm_addr, sm_ll, sm_fl,
                 ex[b], ey[b], ea[b], ell[b], efl[b]);
      end
      @(negedge clk);
    end
    sm_frames = 1;
    vectors++;
    if (sm_done !== 1'b1 || sm_valid !== 1'b0 || sm_fc !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL single_done: got d=%b v=%b fc=%0d want d=1 v=0 fc=1",
               sm_done, sm_valid, sm_fc);
    end
    @(negedge clk);
    vectors++;
    if (sm_done !== 1'b0 || sm_valid !== 1'b0 || sm_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_idle: got d=%b v=%b b=%b want 0 0 0",
               sm_done, sm_valid, sm_busy);
    end
  endtask

  // Random backpressure plus stray start pulses during SCAN and DONE.
  task automatic test_backpressure();
    int k;
    int guard;
    int p;
    int nb = (8 * 2) / 4;
    for (int f = 0; f < 3; f++) begin
      sm_start = 1'b1;
      @(negedge clk);
      sm_start = 1'b0;
      k = 0;
      guard = 0;
      while (k < nb && guard < 200) begin
        p = k * 4;
        vectors++;
        if (sm_valid !== 1'b1 || sm_x !== (p % 8) || sm_y !== (p / 8) || sm_addr !== p ||
            sm_ll !== ((p % 8) == 4) || sm_fl !== (k == nb - 1) ||
            sm_fc !== sm_frames[7:0] || sm_done !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL bp_f%0d_beat%0d: got v=%b x=%0d y=%0d a=%0d ll=%b fl=%b fc=%0d d=%b want v=1 x=%0d y=%0d a=%0d ll=%b fl=%b fc=%0d d=0",
                   f, k, sm_valid, sm_x, sm_y, sm_addr, sm_ll, sm_fl, sm_fc, sm_done,
                   p % 8, p / 8, p, (p % 8) == 4, k == nb - 1, sm_frames[7:0]);
        end
        sm_ready = ($urandom_range(0, 2) != 0);
        sm_start = 1'($urandom_range(0, 1));
        if (sm_ready) k++;
        guard++;
        @(negedge clk);
      end
      vectors++;
      if (k != nb) begin
        miscompares++;
        $display("[TB] FAIL bp_f%0d_timeout: got %0d beats want %0d", f, k, nb);
      end
      sm_frames++;
      sm_start = 1'b1;
      vectors++;
      if (sm_done !== 1'b1 || sm_valid !== 1'b0 || sm_busy !== 1'b0 || sm_fc !== sm_frames[7:0]) begin
        miscompares++;
        $display("[TB] FAIL bp_f%0d_done: got d=%b v=%b b=%b fc=%0d want d=1 v=0 b=0 fc=%0d",
                 f, sm_done, sm_valid, sm_busy, sm_fc, sm_frames[7:0]);
      end
      @(negedge clk);
      sm_start = 1'b0;
      vectors++;
      if (sm_done !== 1'b0 || sm_valid !== 1'b0 || sm_busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_f%0d_idle: got d=%b v=%b b=%b want 0 0 0",
                 f, sm_done, sm_valid, sm_busy);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    sm_ready = 1'b1;
    sm_start = 1'b1;
    @(negedge clk);
    sm_start = 1'b0;
    vectors++;
    if (sm_valid !== 1'b1 || sm_x !== 3'd0 || sm_y !== 1'd0 || sm_addr !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_beat0: got v=%b x=%0d y=%0d a=%0d want 1 0 0 0",
               sm_valid, sm_x, sm_y, sm_addr);
    end
    @(negedge clk);
    vectors++;
    if (sm_valid !== 1'b1 || sm_x !== 3'd4 || sm_y !== 1'd0 || sm_addr !== 4'd4) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_beat1: got v=%b x=%0d y=%0d a=%0d want 1 4 0 4",
               sm_valid, sm_x, sm_y, sm_addr);
    end
    sm_rst = 1'b1;
    @(negedge clk);
    sm_rst = 1'b0;
    vectors++;
    if (sm_valid !== 1'b0 || sm_busy !== 1'b0 || sm_x !== 3'd0 || sm_y !== 1'd0 ||
        sm_addr !== 4'd0 || sm_fc !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_cleared: got v=%b b=%b x=%0d y=%0d a=%0d fc=%0d want all 0",
               sm_valid, sm_busy, sm_x, sm_y, sm_addr, sm_fc);
    end
    sm_frames = 0;
    @(negedge clk);
    vectors++;
    if (sm_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_idle: got v=%b want 0", sm_valid);
    end
    sm_start = 1'b1;
    @(negedge clk);
    sm_start = 1'b0;
    vectors++;
    if (sm_valid !== 1'b1 || sm_x !== 3'd0 || sm_y !== 1'd0 || sm_addr !== 4'd0 || sm_fc !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_restart: got v=%b x=%0d y=%0d a=%0d fc=%0d want 1 0 0 0 0",
               sm_valid, sm_x, sm_y, sm_addr, sm_fc);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (sm_done !== 1'b1 || sm_fc !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_done: got d=%b fc=%0d want d=1 fc=1", sm_done, sm_fc);
    end
    @(negedge clk);
  endtask

  task automatic test_continuous();
    int g = 0;
    int guard = 0;
    int k;
    int p;
    ct_start = 1'b1;
    @(negedge clk);
    ct_start = 1'b0;
    while (g < 12 && guard < 300) begin
      k = g % 4;
      p = k * 4;
      vectors++;
      if (ct_valid !== 1'b1 || ct_done !== 1'b0 || ct_x !== (p % 8) || ct_y !== (p / 8) ||
          ct_addr !== p || ct_ll !== ((p % 8) == 4) || ct_fl !== (k == 3) || ct_fc !== (g / 4)) begin
        miscompares++;
        $display("[TB] FAIL cont_beat%0d: got v=%b d=%b x=%0d y=%0d a=%0d ll=%b fl=%b fc=%0d want v=1 d=0 x=%0d y=%0d a=%0d ll=%b fl=%b fc=%0d",
                 g, ct_valid, ct_done, ct_x, ct_y, ct_addr, ct_ll, ct_fl, ct_fc,
                 p % 8, p / 8, p, (p % 8) == 4, k == 3, g / 4);
      end
      ct_ready = ($urandom_range(0, 3) != 0);
      ct_start = 1'($urandom_range(0, 1));
      if (ct_ready) g++;
      guard++;
      @(negedge clk);
    end
    ct_ready = 1'b0;
    ct_start = 1'b0;
    vectors++;
    if (g != 12 || ct_valid !== 1'b1 || ct_done !== 1'b0 || ct_fc !== 8'd3 ||
        ct_x !== 3'd0 || ct_y !== 1'd0 || ct_addr !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL cont_after12: got beats=%0d v=%b d=%b fc=%0d x=%0d y=%0d a=%0d want 12 1 0 3 0 0 0",
               g, ct_valid, ct_done, ct_fc, ct_x, ct_y, ct_addr);
    end
  endtask

  // One-line, one-beat image: every beat ends both its line and the frame,
  // and frame_count runs past 255 to check the silent wrap.
  task automatic test_edge();
    int n = 0;
    ed_start = 1'b1;
    @(negedge clk);
    ed_start = 1'b0;
    for (int i = 0; i < 600; i++) begin
      vectors++;
      if (ed_valid !== 1'b1 || ed_x !== 2'd0 || ed_y !== 1'd0 || ed_addr !== 2'd0 ||
          ed_ll !== 1'b1 || ed_fl !== 1'b1 || ed_done !== 1'b0 || ed_fc !== (n % 256)) begin
        miscompares++;
        $display("[TB] FAIL edge_cycle%0d: got v=%b x=%0d y=%0d a=%0d ll=%b fl=%b d=%b fc=%0d want v=1 x=0 y=0 a=0 ll=1 fl=1 d=0 fc=%0d",
                 i, ed_valid, ed_x, ed_y, ed_addr, ed_ll, ed_fl, ed_done, ed_fc, n % 256);
      end
      ed_ready = ($urandom_range(0, 7) != 0);
      if (ed_ready) n++;
      @(negedge clk);
    end
    ed_ready = 1'b0;
  endtask

  task automatic test_full_frame();
    int nb = (320 * 240) / 4;
    int k = 0;
    int guard = 0;
    int p;
    int lx = -1;
    int ly = -1;
    int la = -1;
    fl_start = 1'b1;
    @(negedge clk);
    fl_start = 1'b0;
    while (k < nb && guard < 40000) begin
      p = k * 4;
      vectors++;
      if (fl_valid !== 1'b1 || fl_x !== (p % 320) || fl_y !== (p / 320) || fl_addr !== p ||
          fl_ll !== ((p % 320) == 316) || fl_fl !== (k == nb - 1)) begin
        miscompares++;
        $display("[TB] FAIL full_beat%0d: got v=%b x=%0d y=%0d a=%0d ll=%b fl=%b want v=1 x=%0d y=%0d a=%0d ll=%b fl=%b",
                 k, fl_valid, fl_x, fl_y, fl_addr, fl_ll, fl_fl,
                 p % 320, p / 320, p, (p % 320) == 316, k == nb - 1);
      end
      fl_ready = ($urandom_range(0, 7) != 0);
      if (fl_ready) begin
        lx = int'(fl_x);
        ly = int'(fl_y);
        la = int'(fl_addr);
        k++;
      end
      guard++;
      @(negedge clk);
    end
    vectors++;
    if (k != 19200 || lx != 316 || ly != 239 || la != 76796) begin
      miscompares++;
      $display("[TB] FAIL full_last: got beats=%0d x=%0d y=%0d a=%0d want 19200 316 239 76796",
               k, lx, ly, la);
    end
    vectors++;
    if (fl_done !== 1'b1 || fl_valid !== 1'b0 || fl_fc !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL full_done: got d=%b v=%b fc=%0d want d=1 v=0 fc=1",
               fl_done, fl_valid, fl_fc);
    end
    @(negedge clk);
    vectors++;
    if (fl_done !== 1'b0 || fl_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_idle: got d=%b b=%b want 0 0", fl_done, fl_busy);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_reset_mid_scan();
    test_continuous();
    test_edge();
    test_full_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
